control_hazard_stall: RTL
=========================

# control_hazard_stall

Central pipeline hazard and stall sequencer for the 5-stage RISC-V core. It sits beside the EX-stage bypass logic and resolves what forwarding cannot: load-use hazards, multi-cycle MUL/DIV occupancy of EX, data-memory wait states and taken-branch flushes. It drives the write enables and bubble/flush controls of the PC and every pipeline register. A small FSM and down-counter sequence multi-cycle EX operations, and a wait counter flags stuck memory accesses.

## Interface
Parameters:
- MUL_LAT, 3: total EX cycles for a multiply, legal range 2..63.
- DIV_LAT, 33: total EX cycles for a divide, legal range 2..63.
- MEM_TIMEOUT, 255: consecutive memory-stall cycles before `mem_error` sets, legal range 1..1023.

Ports:
- clock, input, 1: sole clock, rising edge.
- reset, input, 1: asynchronous, active-high.
- ifid_rs1 / ifid_rs2, input, 5 each: source registers of the instruction in ID.
- ifid_uses_rs1 / ifid_uses_rs2, input, 1 each: the ID instruction actually reads that source.
- idex_rd, input, 5: destination register of the instruction in EX.
- idex_memread, input, 1: the EX instruction is a load.
- idex_multicycle, input, 1: the EX instruction is a MUL/DIV-class operation.
- idex_is_div, input, 1: the multi-cycle operation is a divide/remainder; qualifies `idex_multicycle`.
- branch_taken, input, 1: the EX instruction redirects the PC.
- dmem_req, input, 1: the MEM-stage instruction accesses data memory.
- dmem_ready, input, 1: the data-memory access completes this cycle.
- pc_write, ifid_write, idex_write, exmem_write, output, 1 each: register update enables.
- ifid_flush, output, 1: load a NOP into IF/ID.
- idex_bubble, exmem_bubble, memwb_bubble, output, 1 each: load a NOP into that register.
- mc_start, output, 1: single-cycle start pulse to the MUL/DIV unit.
- mc_busy, output, 1: FSM is in the BUSY state.
- mem_error, output, 1: sticky memory-timeout flag.

## Operation
- FSM states:
  - RUN (reset state).
  - BUSY: a multi-cycle operation occupies EX. A 6-bit `mc_cnt` counts down.
- `mem_stall = dmem_req & ~dmem_ready`. This is combinational, has the highest priority and is legal in any state.
  - pc_write, ifid_write, idex_write and exmem_write = 0.
  - memwb_bubble = 1.
  - All other flush/bubble outputs = 0.
  - The FSM holds: no transition and no `mc_cnt` decrement.
- RUN, no mem_stall, idex_multicycle = 1:
  - mc_start = 1.
  - `mc_cnt` loads LAT−2, where LAT is DIV_LAT if idex_is_div, else MUL_LAT. Go to BUSY.
  - pc_write, ifid_write and idex_write = 0; exmem_bubble = 1.
- BUSY, no mem_stall:
  - mc_cnt ≠ 0: decrement. Same stall pattern as above; mc_start = 0.
  - mc_cnt = 0: release cycle. All writes = 1, no bubbles, go to RUN. EX/MEM captures the result.
  - idex_multicycle is ignored in BUSY, so the same op never restarts.
- RUN, no mem_stall, no multicycle, branch_taken = 1:
  - ifid_flush = 1 and idex_bubble = 1.
  - pc_write = 1 so the redirect target is loaded.
- RUN, none of the above, load-use hazard: `idex_memread & idex_rd≠0 & ((uses_rs1 & rs1==rd) | (uses_rs2 & rs2==rd))`.
  - pc_write = 0, ifid_write = 0, idex_bubble = 1.
  - idex_write and exmem_write = 1.
- Otherwise: all writes = 1, all flush/bubble = 0, mc_start = 0.
- Bubble/flush outputs are asserted together with the matching write enable where relevant; a register with write = 0 ignores its bubble.
- Memory timeout:
  - 10-bit `mem_wait_cnt` increments each mem_stall cycle and saturates at MEM_TIMEOUT.
  - It clears on any cycle without mem_stall.
  - When it reaches MEM_TIMEOUT, `mem_error` sets and stays set until reset. The stall continues regardless.

## Timing
- Reset (asynchronous):
  - state = RUN, mc_cnt = 0, mem_wait_cnt = 0, mem_error = 0.
  - With idle inputs the outputs are pc_write = ifid_write = idex_write = exmem_write = 1, all bubbles/flush = 0, mc_start = 0, mc_busy = 0.
- Reset asserted mid-BUSY returns to RUN immediately; no release cycle occurs.
- All control outputs are combinational from state and inputs, with no registered delay. Only mem_error and mc_busy are pure state.
- Multi-cycle op with no memory stall: stall cycles = LAT−1, then one release cycle, so EX occupancy = LAT cycles.
  - MUL_LAT = 3: start cycle, one BUSY count cycle, release.
  - Each mem_stall cycle inside BUSY adds exactly one cycle.
- Load-use costs exactly one bubble. Taken branch costs two flushed slots.
- mem_error rises on the clock edge that completes the MEM_TIMEOUT-th consecutive stall cycle.

## Test plan
- Reset with idle inputs, then release:
  - all write enables = 1, bubbles = 0, mc_busy = 0, mem_error = 0.
  - Assert reset mid-BUSY: mc_busy drops immediately.
- Load x5 in EX (idex_memread = 1, idex_rd = 5) with ID rs2 = 5, uses_rs2 = 1:
  - one cycle of pc_write = 0, ifid_write = 0, idex_bubble = 1.
  - The same case with idex_rd = 0 or uses_rs2 = 0 gives no stall.
- MUL with MUL_LAT = 3:
  - mc_start pulses once, then 2 stall cycles with exmem_bubble = 1, then a release cycle with all writes = 1.
  - DIV with DIV_LAT = 33 holds EX for 33 cycles in total.
- dmem_ready low for 4 cycles during a DIV in BUSY:
  - all writes = 0 and memwb_bubble = 1 on those cycles.
  - Total DIV occupancy = 37 cycles.
- branch_taken with load-use also true:
  - ifid_flush = 1, idex_bubble = 1, pc_write = 1 (branch wins).
  - branch_taken during mem_stall: no flush.
- MEM_TIMEOUT = 4:
  - 4 consecutive stall cycles set mem_error.
  - mem_error stays high after dmem_ready returns until reset.
  - 3 stall cycles followed by a ready cycle leave mem_error = 0.

Source files
------------

// File: rtl/control_hazard_stall.sv
// control_hazard_stall: pipeline hazard/stall sequencer for a 5-stage RISC-V core.
//   Inputs : clock_i, reset_i (async, active-high), ID source regs/uses, EX rd/load/
//            multicycle/div flags, branch_taken_i, MEM-stage dmem_req_i/dmem_ready_i.
//   Outputs: PC and pipeline-register write enables, IF/ID flush, ID/EX, EX/MEM and
//            MEM/WB bubbles, MUL/DIV start pulse, busy state and sticky memory timeout.
module control_hazard_stall #(
   parameter int MUL_LAT     = 3,
   parameter int DIV_LAT     = 33,
   parameter int MEM_TIMEOUT = 255
) (
   input  logic       clock_i,
   input  logic       reset_i,
   input  logic [4:0] ifid_rs1_i,
   input  logic [4:0] ifid_rs2_i,
   input  logic       ifid_uses_rs1_i,
   input  logic       ifid_uses_rs2_i,
   input  logic [4:0] idex_rd_i,
   input  logic       idex_memread_i,
   input  logic       idex_multicycle_i,
   input  logic       idex_is_div_i,
   input  logic       branch_taken_i,
   input  logic       dmem_req_i,
   input  logic       dmem_ready_i,
   output logic       pc_write_o,
   output logic       ifid_write_o,
   output logic       idex_write_o,
   output logic       exmem_write_o,
   output logic       ifid_flush_o,
   output logic       idex_bubble_o,
   output logic       exmem_bubble_o,
   output logic       memwb_bubble_o,
   output logic       mc_start_o,
   output logic       mc_busy_o,
   output logic       mem_error_o
);
   typedef enum logic {RUN, BUSY} state_t;
   state_t     state_q, state_d;
   logic [5:0] mc_cnt_q, mc_cnt_d;
   logic [9:0] mem_wait_q, mem_wait_d;
   logic       mem_error_q, mem_error_d;
   logic       mem_stall, load_use;
   assign mem_stall = dmem_req_i & ~dmem_ready_i;
   assign load_use  = idex_memread_i & (idex_rd_i != 5'd0) &
                      ((ifid_uses_rs1_i & (ifid_rs1_i == idex_rd_i)) |
                       (ifid_uses_rs2_i & (ifid_rs2_i == idex_rd_i)));
   // A memory stall freezes everything, including the multi-cycle sequencer.
   always_comb begin
      pc_write_o     = 1'b1;
      ifid_write_o   = 1'b1;
      idex_write_o   = 1'b1;
      exmem_write_o  = 1'b1;
      ifid_flush_o   = 1'b0;
      idex_bubble_o  = 1'b0;
      exmem_bubble_o = 1'b0;
      memwb_bubble_o = 1'b0;
      mc_start_o     = 1'b0;
      state_d        = state_q;
      mc_cnt_d       = mc_cnt_q;
      if (mem_stall) begin
         pc_write_o     = 1'b0;
         ifid_write_o   = 1'b0;
         idex_write_o   = 1'b0;
         exmem_write_o  = 1'b0;
         memwb_bubble_o = 1'b1;
      end else if (state_q == BUSY) begin
         if (mc_cnt_q != 6'd0) begin
            mc_cnt_d       = mc_cnt_q - 6'd1;
            pc_write_o     = 1'b0;
            ifid_write_o   = 1'b0;
            idex_write_o   = 1'b0;
            exmem_bubble_o = 1'b1;
         end else begin
            state_d = RUN;
         end
      end else if (idex_multicycle_i) begin
         // Start cycle plus the counted cycles plus release equals LAT.
         mc_start_o     = 1'b1;
         mc_cnt_d       = idex_is_div_i ? 6'(DIV_LAT - 2) : 6'(MUL_LAT - 2);
         state_d        = BUSY;
         pc_write_o     = 1'b0;
         ifid_write_o   = 1'b0;
         idex_write_o   = 1'b0;
         exmem_bubble_o = 1'b1;
      end else if (branch_taken_i) begin
         ifid_flush_o  = 1'b1;
         idex_bubble_o = 1'b1;
      end else if (load_use) begin
         pc_write_o    = 1'b0;
         ifid_write_o  = 1'b0;
         idex_bubble_o = 1'b1;
      end
   end
   always_comb begin
      mem_wait_d  = !mem_stall ? 10'd0 :
                    (mem_wait_q == 10'(MEM_TIMEOUT)) ? mem_wait_q : mem_wait_q + 10'd1;
      mem_error_d = mem_error_q | (mem_wait_d == 10'(MEM_TIMEOUT));
   end
   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state_q     <= RUN;
         mc_cnt_q    <= 6'd0;
         mem_wait_q  <= 10'd0;
         mem_error_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         mc_cnt_q    <= mc_cnt_d;
         mem_wait_q  <= mem_wait_d;
         mem_error_q <= mem_error_d;
      end
   end
   assign mc_busy_o   = (state_q == BUSY);
   assign mem_error_o = mem_error_q;
endmodule
